// File: rtl/regfile_wr_demux32.sv
// -----------------------------------------------------------------------------
// regfile_wr_demux32
//
// Integer register file for the pipelined datapath. The WB stage writes and
// the ID stage reads. A 5-to-32 one-hot decoder steers the write into one of
// 32 storage registers. Two independent read ports select a register with a
// 32-to-1 mux. An optional bypass forwards the write data to a read port that
// addresses the register being written in the same cycle.
//
// Parameters
//   N_BITS    width of each register and of the data ports
//   BYPASS    1: forward same-cycle write data to a matching read port
//   ZERO_REG  1: r0 always reads as zero and ignores writes
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset, clears every register
//   wr_en      in   1       write request for this cycle
//   wr_addr    in   5       destination register index
//   wr_data    in   N_BITS  data to write
//   rd_addr_a  in   5       read port A index
//   rd_addr_b  in   5       read port B index
//   rd_data_a  out  N_BITS  read port A data (combinational)
//   rd_data_b  out  N_BITS  read port B data (combinational)
//   wr_strobe  out  32      one-hot per-register write enable (combinational)
// -----------------------------------------------------------------------------
module regfile_wr_demux32 #(
    parameter int N_BITS   = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [N_BITS-1:0] wr_data,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [N_BITS-1:0] rd_data_a,
    output logic [N_BITS-1:0] rd_data_b,
    output logic [31:0]       wr_strobe
);

    logic [N_BITS-1:0] regs_q [32];
    logic [N_BITS-1:0] regs_d [32];

    // Write decoder. r0 is masked here when it is hard-wired to zero, so the
    // same strobe both blocks the storage update and disables the bypass.
    always_comb begin
        wr_strobe = '0;
        for (int i = 0; i < 32; i++) begin
            wr_strobe[i] = wr_en && (wr_addr == 5'(i));
        end
        if (ZERO_REG != 0) begin
            wr_strobe[0] = 1'b0;
        end
    end

    // Next-state of the storage array: only the strobed register changes.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_strobe[i]) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Reset takes priority over a coincident write; the write is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port A. Bypass is checked first so that a write landing on the
    // addressed register is seen in the same cycle; the r0 check follows so
    // that a masked r0 write can never leak through.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if ((BYPASS != 0) && wr_strobe[rd_addr_a]) begin
            rd_data_a = wr_data;
        end else if ((ZERO_REG != 0) && (rd_addr_a == 5'd0)) begin
            rd_data_a = '0;
        end
    end

    // Read port B, identical selection to port A.
    always_comb begin
        rd_data_b = regs_q[rd_addr_b];
        if ((BYPASS != 0) && wr_strobe[rd_addr_b]) begin
            rd_data_b = wr_data;
        end else if ((ZERO_REG != 0) && (rd_addr_b == 5'd0)) begin
            rd_data_b = '0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_demux32.sv
module tb_regfile_wr_demux32;

    localparam int N_BITS   = 32;
    localparam int BYPASS   = 1;
    localparam int ZERO_REG = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [N_BITS-1:0] wr_data;
    logic [4:0]        rd_addr_a;
    logic [4:0]        rd_addr_b;
    logic [N_BITS-1:0] rd_data_a;
    logic [N_BITS-1:0] rd_data_b;
    logic [31:0]       wr_strobe;

    regfile_wr_demux32 #(
        .N_BITS   (N_BITS),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_strobe (wr_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] strobe;
        logic [31:0] rda;
        logic [31:0] rdb;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected read value from the reference model for the current cycle.
    function automatic logic [31:0] exp_read(input logic [4:0] addr,
                                             input logic en,
                                             input logic [4:0] waddr,
                                             input logic [31:0] wdata);
        if (BYPASS != 0 && en && waddr == addr && !(ZERO_REG != 0 && addr == 5'd0))
            return wdata;
        if (ZERO_REG != 0 && addr == 5'd0)
            return 32'h0;
        return model[addr];
    endfunction

    // One clock cycle: drive inputs, push expectations, compare at the
    // falling edge, then update the model at the rising edge.
    task automatic cycle(input string tag, input logic rstn, input logic en,
                         input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input bit do_check);
        exp_t e;
        exp_t g;
        rst_n     = rstn;
        wr_en     = en;
        wr_addr   = waddr;
        wr_data   = wdata;
        rd_addr_a = ra;
        rd_addr_b = rb;
        e.tag    = tag;
        e.strobe = (en && !(ZERO_REG != 0 && waddr == 5'd0)) ? (32'h1 << waddr) : 32'h0;
        e.rda    = exp_read(ra, en, waddr, wdata);
        e.rdb    = exp_read(rb, en, waddr, wdata);
        if (do_check) sb.push_back(e);
        @(negedge clk);
        if (do_check && sb.size() > 0) begin
            g = sb.pop_front();
            check_val($sformatf("%s.strobe", g.tag), wr_strobe, g.strobe);
            check_val($sformatf("%s.rd_a",   g.tag), rd_data_a, g.rda);
            check_val($sformatf("%s.rd_b",   g.tag), rd_data_b, g.rdb);
        end
        @(posedge clk);
        if (!rstn) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (e.strobe != 32'h0) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            cycle($sformatf("%s%0d", tag, i), 1'b1, 1'b0, 5'd0, 32'h0,
                  5'(i), 5'(31 - i), 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        @(posedge clk); #1;
        cycle("init_rst", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);

        // 1. Fill with ones, reset for one edge, everything must read zero.
        for (int i = 0; i < 32; i++)
            cycle($sformatf("fill%0d", i), 1'b1, 1'b1, 5'(i), 32'hFFFF_FFFF,
                  5'((i + 1) % 32), 5'((i + 2) % 32), 1'b1);
        read_all("pre_rst");
        cycle("rst_pulse", 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1);
        read_all("post_rst");

        // 2. Walk a distinct value into every register.
        for (int i = 1; i < 32; i++)
            cycle($sformatf("walk%0d", i), 1'b1, 1'b1, 5'(i), 32'hA5A5_0000 | i,
                  5'(i - 1), 5'(0), 1'b1);
        read_all("walk_rd");

        // 3. Writes to r0 are suppressed and never forwarded.
        cycle("zero_wr", 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b1);
        cycle("zero_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);

        // 4. Same-cycle write-then-read, then the stored value.
        cycle("byp_wr", 1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 1'b1);
        cycle("byp_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1);

        // 5. Write coinciding with reset is lost.
        cycle("rc_pre", 1'b1, 1'b1, 5'd3, 32'h0000_00AA, 5'd1, 5'd2, 1'b1);
        cycle("rc_hit", 1'b0, 1'b1, 5'd3, 32'h0000_0055, 5'd4, 5'd4, 1'b1);
        cycle("rc_rd",  1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1);

        // 6. Back-to-back writes, then full scoreboard sweep.
        cycle("b2b_0", 1'b1, 1'b1, 5'd5, 32'h1, 5'd5, 5'd6, 1'b1);
        cycle("b2b_1", 1'b1, 1'b1, 5'd5, 32'h2, 5'd5, 5'd6, 1'b1);
        cycle("b2b_2", 1'b1, 1'b1, 5'd6, 32'h3, 5'd5, 5'd6, 1'b1);
        read_all("b2b_rd");

        // Random traffic against the model.
        for (int k = 0; k < 60; k++)
            cycle($sformatf("rnd%0d", k), 1'b1, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
